// File: rtl/rv32im_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional: RV32IM_DIV_FAST_SPECIAL_EN gives divide-by-zero/overflow a 1-cycle path.
module rv32im_div #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

`ifdef RV32IM_DIV_FAST_SPECIAL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE, RUN, SPEC, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] dq_q, prem_q, dvs_q, raw_q;
  logic [CW-1:0]   cnt_q;
  logic            q_neg_q, r_neg_q, dz_q, ovf_q;

  logic            dvd_neg, dvs_neg, dz, ovf;
  logic [XLEN:0]   shifted, diff;
  logic            ge, last, load;
  logic [XLEN-1:0] prem_nx, dq_nx, q_res, r_res;

  assign dvd_neg = signed_i & dividend_i[XLEN-1];
  assign dvs_neg = signed_i & divisor_i[XLEN-1];
  assign dz      = divisor_i == '0;
  assign ovf     = signed_i & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (&divisor_i);

  // Partial remainder kept one bit wider so large unsigned divisors work.
  assign shifted = {prem_q, dq_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign prem_nx = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dq_nx   = {dq_q[XLEN-2:0], ge};
  assign last    = cnt_q == CW'(XLEN-1);

  always_comb begin
    q_res = q_neg_q ? -dq_nx : dq_nx;
    r_res = r_neg_q ? -prem_nx : prem_nx;
    if (dz_q) begin
      q_res = '1;
      r_res = raw_q;
    end else if (ovf_q) begin
      q_res = raw_q;
      r_res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (start_i) begin
      state_d = (Fast && (dz || ovf)) ? SPEC : RUN;
    end else begin
      unique case (state_q)
        RUN: if (last) begin
          state_d = DONE;
          load    = 1'b1;
        end
        SPEC: begin
          state_d = DONE;
          load    = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      raw_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        dq_q    <= dvd_neg ? -dividend_i : dividend_i;
        dvs_q   <= dvs_neg ? -divisor_i : divisor_i;
        raw_q   <= dividend_i;
        prem_q  <= '0;
        cnt_q   <= '0;
        q_neg_q <= dvd_neg ^ dvs_neg;
        r_neg_q <= dvd_neg;
        dz_q    <= dz;
        ovf_q   <= ovf;
      end else if (state_q == RUN) begin
        dq_q   <= dq_nx;
        prem_q <= prem_nx;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (load) begin
        quotient_o  <= q_res;
        remainder_o <= r_res;
      end
    end
  end

  assign busy_o  = state_q == RUN;
  assign valid_o = state_q == DONE;

endmodule
